pixel_unpacker: RTL and testbench
=================================

Name: pixel_unpacker

Overview:
- AXI-Stream sink that reverses the pixel packer: accepts 32-bit words carrying 24-bit RGB pixels (4 pixels per 3 words) and emits one pixel per handshake with start-of-frame and end-of-line markers.
- Sits on the receive side of a video stream, e.g. for loopback checks of the ray-tracer output or for consuming frames from VDMA into downstream pixel logic.
- Also reports framing errors and measures line length.

Parameters:
- LINE_CNT_W, 13, width of the pixel-per-line counter and the line_pixels output (matches imageWidth width).

Ports:
- clk  in  1  stream clock
- reset  in  1  synchronous, active-high reset
- in_stream_tdata  in  32  packed pixel bytes
- in_stream_tkeep  in  4  byte enables; must be 4'hF
- in_stream_tlast  in  1  last word of a line
- in_stream_tuser  in  1  first word of a frame
- in_stream_tvalid  in  1  input word valid
- in_stream_tready  out  1  input word accepted this cycle when high with tvalid
- out_red  out  8  pixel red
- out_green  out  8  pixel green
- out_blue  out  8  pixel blue
- out_sof  out  1  pixel is first of frame
- out_eol  out  1  pixel is last of line
- out_valid  out  1  output pixel valid
- out_ready  in  1  downstream accepts pixel
- err_sticky  out  1  framing error latched
- err_clear  in  1  clears err_sticky
- line_pixels  out  LINE_CNT_W  pixel count of last completed line

Behaviour:
- Byte order: each pixel is {r,g,b}, with b in the lowest byte. Words are little-endian.
  - w0 = {b1,r0,g0,b0}
  - w1 = {g2,b2,r1,g1}
  - w2 = {r3,g3,b3,r2}
- Phase counter `ph` runs 0..3, with a 24-bit residue register `res`.
  - ph0: consume w0; pixel = w0[23:0]; res[7:0] = w0[31:24].
  - ph1: consume w1; pixel = {w1[15:8], w1[7:0], res[7:0]}; res[15:0] = w1[31:16].
  - ph2: consume w2; pixel = {w2[7:0], res[15:0]}; res = w2[31:8].
  - ph3: consume nothing; pixel = res.
  - `ph` advances on every pixel load and wraps 3→0.
- Output register: one pixel stage. Load condition is `load = (!out_valid || out_ready)`.
  - in_stream_tready = load && ph != 3 (combinational from out_ready).
  - On a word handshake, the output loads at the next edge.
  - In ph3, the output loads whenever `load` is high, with no input required.
  - When out_valid && out_ready and there is no new load, out_valid drops.
- Latency: 1 cycle from word handshake to out_valid.
- Throughput: 4 pixels per 3 words, giving one input bubble per group at full rate.
- SOF: out_sof = 1 on the pixel produced from a word with tuser = 1 (normally ph0 only).
- EOL:
  - A word with tlast at ph2 sets an internal flag so the following ph3 pixel carries out_eol = 1.
  - The ph2 pixel itself has out_eol = 0.
- Resync rules (both set err_sticky):
  - tuser = 1 at ph != 0: discard `res`; treat the word as w0 (pixel = w0[23:0], out_sof = 1, ph → 1).
  - tlast = 1 at ph0 or ph1: emit that pixel with out_eol = 1; discard `res`; ph → 0.
- tkeep != 4'hF on any accepted word: set err_sticky; data is used as-is.
- Line counter:
  - Counts emitted pixels (at load).
  - On loading an out_eol pixel: line_pixels ← count+1 and count ← 0.
  - A tuser word also resets count to 1.
  - Saturates at all-ones.
- err_sticky: set by any error; cleared by err_clear. Set wins when both occur in the same cycle.
- Reset (synchronous, any time including mid-group): out_valid = 0, out_sof = 0, out_eol = 0, RGB = 0, ph = 0, res = 0, err_sticky = 0, line_pixels = 0, count = 0, in_stream_tready = 0 during reset.
- out_* RGB/sof/eol hold their values while out_valid && !out_ready.

Test Plan:
- Single group: words 0x44332211 (tuser), 0x88776655, 0xCCBBAA99 (tlast), out_ready = 1 → pixels {r,g,b} = 0x332211 (sof), 0x665544, 0x998877, 0xCCBBAA (eol); line_pixels = 4; err_sticky = 0.
- Backpressure: same words, out_ready toggled 1/0 each cycle → identical pixel sequence, no loss or duplication; tready low whenever out_valid && !out_ready.
- 640-pixel line: 480 words, tlast on word 480, streamed back-to-back → 640 pixels, eol on the 640th only; line_pixels = 640; 1 tready bubble per 3 words.
- Early tlast on w1 → that pixel has eol; next word is decoded as w0; err_sticky = 1; err_clear pulse → 0.
- tuser on a w2-position word → that word is decoded as w0 with sof, ph = 1, err_sticky = 1.
- Reset asserted after w1 is accepted → all outputs 0; a subsequent clean 3-word group decodes correctly from ph0.

Source files
------------

// File: rtl/pixel_unpacker.sv
// AXI-Stream sink that unpacks 24-bit RGB pixels from 32-bit words (4 pixels per 3 words).
// Emits one pixel per handshake with SOF/EOL markers, latches framing errors and measures line length.
module pixel_unpacker #(
  parameter int LINE_CNT_W = 13
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           in_stream_tdata,
  input  logic [3:0]            in_stream_tkeep,
  input  logic                  in_stream_tlast,
  input  logic                  in_stream_tuser,
  input  logic                  in_stream_tvalid,
  output logic                  in_stream_tready,
  output logic [7:0]            out_red,
  output logic [7:0]            out_green,
  output logic [7:0]            out_blue,
  output logic                  out_sof,
  output logic                  out_eol,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  err_sticky,
  input  logic                  err_clear,
  output logic [LINE_CNT_W-1:0] line_pixels
);

  typedef enum logic [1:0] {PH0, PH1, PH2, PH3} phase_e;

  phase_e                phase_q, phase_d;
  logic [23:0]           res_q, res_d;
  logic                  eolPend_q, eolPend_d;
  logic [23:0]           pixel_q, pixel_d;
  logic                  outSof_q, outSof_d;
  logic                  outEol_q, outEol_d;
  logic                  outValid_q;
  logic                  errSticky_q;
  logic [LINE_CNT_W-1:0] count_q, count_d;
  logic [LINE_CNT_W-1:0] linePixels_q, linePixels_d;
  logic [LINE_CNT_W-1:0] cntInc;

  logic load, wordHs, ph3Load, pixelLoad, tuserWord, errNow;

  // The output stage may be refilled when empty or when its pixel is taken this cycle.
  assign load             = !outValid_q || out_ready;
  assign in_stream_tready = load && (phase_q != PH3) && !reset;
  assign wordHs           = in_stream_tvalid && in_stream_tready;
  assign ph3Load          = load && (phase_q == PH3) && !reset;
  assign pixelLoad        = wordHs || ph3Load;
  assign tuserWord        = wordHs && in_stream_tuser;

  always_ff @(posedge clk) begin
    if (reset) phase_q <= PH0;
    else       phase_q <= phase_d;
  end

  // A tuser word always restarts the group; tlast before w2 closes the line early.
  always_comb begin
    phase_d = phase_q;
    if (wordHs) begin
      if (in_stream_tuser || phase_q == PH0) begin
        phase_d = in_stream_tlast ? PH0 : PH1;
      end else if (phase_q == PH1) begin
        phase_d = in_stream_tlast ? PH0 : PH2;
      end else begin
        phase_d = PH3;
      end
    end else if (ph3Load) begin
      phase_d = PH0;
    end
  end

  always_comb begin
    pixel_d   = res_q;
    outSof_d  = 1'b0;
    outEol_d  = 1'b0;
    res_d     = res_q;
    eolPend_d = eolPend_q;
    errNow    = 1'b0;
    if (wordHs) begin
      errNow = (in_stream_tkeep != 4'hF) || (in_stream_tuser && phase_q != PH0);
      if (in_stream_tuser || phase_q == PH0) begin
        pixel_d  = in_stream_tdata[23:0];
        outSof_d = in_stream_tuser;
        res_d    = {16'h0000, in_stream_tdata[31:24]};
        if (in_stream_tlast) begin
          outEol_d = 1'b1;
          res_d    = '0;
          errNow   = 1'b1;
        end
      end else if (phase_q == PH1) begin
        pixel_d = {in_stream_tdata[15:8], in_stream_tdata[7:0], res_q[7:0]};
        res_d   = {8'h00, in_stream_tdata[31:16]};
        if (in_stream_tlast) begin
          outEol_d = 1'b1;
          res_d    = '0;
          errNow   = 1'b1;
        end
      end else begin
        pixel_d   = {in_stream_tdata[7:0], res_q[15:0]};
        res_d     = in_stream_tdata[31:8];
        eolPend_d = in_stream_tlast;
      end
    end else if (ph3Load) begin
      pixel_d   = res_q;
      outEol_d  = eolPend_q;
      eolPend_d = 1'b0;
    end
  end

  // Line length counts loaded pixels and saturates rather than wrapping.
  always_comb begin
    cntInc       = (&count_q) ? count_q : count_q + LINE_CNT_W'(1);
    count_d      = count_q;
    linePixels_d = linePixels_q;
    if (pixelLoad) begin
      if (outEol_d) begin
        linePixels_d = tuserWord ? LINE_CNT_W'(1) : cntInc;
        count_d      = '0;
      end else if (tuserWord) begin
        count_d = LINE_CNT_W'(1);
      end else begin
        count_d = cntInc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res_q        <= '0;
      eolPend_q    <= 1'b0;
      pixel_q      <= '0;
      outSof_q     <= 1'b0;
      outEol_q     <= 1'b0;
      outValid_q   <= 1'b0;
      errSticky_q  <= 1'b0;
      count_q      <= '0;
      linePixels_q <= '0;
    end else begin
      res_q        <= res_d;
      eolPend_q    <= eolPend_d;
      count_q      <= count_d;
      linePixels_q <= linePixels_d;
      errSticky_q  <= errNow || (errSticky_q && !err_clear);
      if (pixelLoad) begin
        pixel_q    <= pixel_d;
        outSof_q   <= outSof_d;
        outEol_q   <= outEol_d;
        outValid_q <= 1'b1;
      end else if (load) begin
        outValid_q <= 1'b0;
      end
    end
  end

  assign out_red     = pixel_q[23:16];
  assign out_green   = pixel_q[15:8];
  assign out_blue    = pixel_q[7:0];
  assign out_sof     = outSof_q;
  assign out_eol     = outEol_q;
  assign out_valid   = outValid_q;
  assign err_sticky  = errSticky_q;
  assign line_pixels = linePixels_q;

endmodule

// File: tb/tb_pixel_unpacker.sv
// Directed bench for pixel_unpacker: words go in through applyStimulus, pixels are collected
// on the falling edge and compared with hand-computed values through checkOutput.
module tb_pixel_unpacker;

  localparam int LINE_CNT_W = 13;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [31:0]           tdata = '0;
  logic [3:0]            tkeep = 4'hF;
  logic                  tlast = 1'b0;
  logic                  tuser = 1'b0;
  logic                  tvalid = 1'b0;
  logic                  tready;
  logic [7:0]            outRed, outGreen, outBlue;
  logic                  outSof, outEol, outValid;
  logic                  outReady = 1'b1;
  logic                  errSticky;
  logic                  errClear = 1'b0;
  logic [LINE_CNT_W-1:0] linePixels;

  int vectors = 0;
  int miscompares = 0;
  int bubbles = 0;
  bit bpMode = 1'b0;
  logic [25:0] pixQ[$];
  logic [25:0] expQ[$];

  pixel_unpacker #(.LINE_CNT_W(LINE_CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_stream_tdata(tdata), .in_stream_tkeep(tkeep), .in_stream_tlast(tlast),
    .in_stream_tuser(tuser), .in_stream_tvalid(tvalid), .in_stream_tready(tready),
    .out_red(outRed), .out_green(outGreen), .out_blue(outBlue),
    .out_sof(outSof), .out_eol(outEol), .out_valid(outValid), .out_ready(outReady),
    .err_sticky(errSticky), .err_clear(errClear), .line_pixels(linePixels)
  );

  always #5 clk = ~clk;

  // Downstream ready is either held high or toggled every cycle for backpressure.
  always @(posedge clk) begin
    #1;
    if (bpMode) outReady = ~outReady;
    else        outReady = 1'b1;
  end

  always @(negedge clk) begin
    if (!reset && outValid && outReady)
      pixQ.push_back({outSof, outEol, outRed, outGreen, outBlue});
    if (bpMode && !reset && outValid && !outReady)
      checkOutput("bp_tready", 32'(tready), 32'd0);
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [31:0] data, input logic user, input logic last,
                               input logic [3:0] keep);
    bit done;
    int waits;
    done  = 1'b0;
    waits = 0;
    tdata = data; tuser = user; tlast = last; tkeep = keep; tvalid = 1'b1;
    while (!done && waits < 100) begin
      @(negedge clk);
      if (tready) done = 1'b1;
      else        bubbles++;
      @(posedge clk);
      #1;
      waits++;
    end
    if (!done) checkOutput("hs_timeout", 32'd0, 32'd1);
    tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0; tkeep = 4'hF;
  endtask

  function automatic logic [25:0] px(input logic sof, input logic eol, input logic [23:0] rgb);
    return {sof, eol, rgb};
  endfunction

  function automatic logic [7:0] byteAt(input int k);
    return 8'((k * 7 + 3) & 255);
  endfunction

  task automatic expectPixels(input string tag);
    int waits;
    waits = 0;
    while (pixQ.size() < expQ.size() && waits < 2000) begin
      tick(1);
      waits++;
    end
    tick(8);
    checkOutput({tag, "_count"}, 32'(pixQ.size()), 32'(expQ.size()));
    foreach (expQ[i])
      if (i < pixQ.size())
        checkOutput($sformatf("%s_px%0d", tag, i), 32'(pixQ[i]), 32'(expQ[i]));
    pixQ.delete();
    expQ.delete();
  endtask

  task automatic sendGroup();
    applyStimulus(32'h44332211, 1'b1, 1'b0, 4'hF);
    applyStimulus(32'h88776655, 1'b0, 1'b0, 4'hF);
    applyStimulus(32'hCCBBAA99, 1'b0, 1'b1, 4'hF);
    expQ = '{px(1, 0, 24'h332211), px(0, 0, 24'h665544), px(0, 0, 24'h998877),
             px(0, 1, 24'hCCBBAA)};
  endtask

  initial begin
    tick(2);
    checkOutput("rst_tready", 32'(tready), 32'd0);
    checkOutput("rst_valid", 32'(outValid), 32'd0);
    checkOutput("rst_err", 32'(errSticky), 32'd0);
    checkOutput("rst_line", 32'(linePixels), 32'd0);
    checkOutput("rst_rgb", {8'h00, outRed, outGreen, outBlue}, 32'd0);
    reset = 1'b0;
    tick(1);

    sendGroup();
    expectPixels("grp");
    checkOutput("grp_line", 32'(linePixels), 32'd4);
    checkOutput("grp_err", 32'(errSticky), 32'd0);

    bpMode = 1'b1;
    sendGroup();
    expectPixels("bp");
    bpMode = 1'b0;
    tick(2);
    checkOutput("bp_line", 32'(linePixels), 32'd4);

    bubbles = 0;
    for (int j = 0; j < 480; j++)
      applyStimulus({byteAt(4*j+3), byteAt(4*j+2), byteAt(4*j+1), byteAt(4*j)},
                    (j == 0), (j == 479), 4'hF);
    checkOutput("line_bubbles", 32'(bubbles), 32'd159);
    for (int i = 0; i < 640; i++)
      expQ.push_back(px((i == 0), (i == 639), {byteAt(3*i+2), byteAt(3*i+1), byteAt(3*i)}));
    expectPixels("line");
    checkOutput("line_len", 32'(linePixels), 32'd640);
    checkOutput("line_err", 32'(errSticky), 32'd0);

    applyStimulus(32'h03020100, 1'b1, 1'b0, 4'hF);
    applyStimulus(32'h07060504, 1'b0, 1'b1, 4'hF);
    applyStimulus(32'h0B0A0908, 1'b0, 1'b0, 4'hF);
    applyStimulus(32'h0F0E0D0C, 1'b0, 1'b0, 4'hF);
    applyStimulus(32'h13121110, 1'b0, 1'b1, 4'hF);
    expQ = '{px(1, 0, 24'h020100), px(0, 1, 24'h050403), px(0, 0, 24'h0A0908),
             px(0, 0, 24'h0D0C0B), px(0, 0, 24'h100F0E), px(0, 1, 24'h131211)};
    expectPixels("early");
    checkOutput("early_err", 32'(errSticky), 32'd1);
    checkOutput("early_line", 32'(linePixels), 32'd4);
    errClear = 1'b1;
    tick(1);
    errClear = 1'b0;
    checkOutput("clr_err", 32'(errSticky), 32'd0);

    applyStimulus(32'h23222120, 1'b1, 1'b0, 4'hF);
    applyStimulus(32'h27262524, 1'b0, 1'b0, 4'hF);
    applyStimulus(32'h2B2A2928, 1'b1, 1'b0, 4'hF);
    applyStimulus(32'h2F2E2D2C, 1'b0, 1'b0, 4'hF);
    applyStimulus(32'h33323130, 1'b0, 1'b1, 4'hF);
    expQ = '{px(1, 0, 24'h222120), px(0, 0, 24'h252423), px(1, 0, 24'h2A2928),
             px(0, 0, 24'h2D2C2B), px(0, 0, 24'h302F2E), px(0, 1, 24'h333231)};
    expectPixels("resync");
    checkOutput("resync_err", 32'(errSticky), 32'd1);
    checkOutput("resync_line", 32'(linePixels), 32'd4);
    errClear = 1'b1;
    tick(1);
    errClear = 1'b0;

    applyStimulus(32'h44332211, 1'b1, 1'b0, 4'hF);
    applyStimulus(32'h88776655, 1'b0, 1'b0, 4'h7);
    checkOutput("keep_err", 32'(errSticky), 32'd1);
    reset = 1'b1;
    tick(1);
    checkOutput("mid_tready", 32'(tready), 32'd0);
    checkOutput("mid_valid", 32'(outValid), 32'd0);
    checkOutput("mid_flags", {30'd0, outSof, outEol}, 32'd0);
    checkOutput("mid_rgb", {8'h00, outRed, outGreen, outBlue}, 32'd0);
    checkOutput("mid_err", 32'(errSticky), 32'd0);
    checkOutput("mid_line", 32'(linePixels), 32'd0);
    tick(1);
    reset = 1'b0;
    pixQ.delete();
    tick(1);
    sendGroup();
    expectPixels("post");
    checkOutput("post_line", 32'(linePixels), 32'd4);
    checkOutput("post_err", 32'(errSticky), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
